ws2812_rx: RTL

// - Receiver/decoder for the single-wire WS2812 NRZ LED stream that led_shifter transmits.
// - Measures high-pulse widths on din and decodes each pulse to a 0 or 1 bit.
// - Assembles bits into 24-bit pixel words and detects the latch gap that ends a frame.
// - Used as an on-FPGA loopback checker for the LED path, and as the front end of a pixel emulator.

---
 rtl/ws2812_pkg.sv | 31 +++
 rtl/ws2812_rx_din_sync.sv | 34 +++
 rtl/ws2812_rx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared WS2812 timing constants, receiver state encoding and a
// saturating width-counter helper. Timing values assume a 24 MHz clock.
package ws2812_pkg;

    localparam int MIN_HIGH_CYC   = 4;     // shorter highs are glitches
    localparam int BIT_THRESH_CYC = 14;    // high width >= this decodes as 1
    localparam int MAX_HIGH_CYC   = 40;    // longer highs are protocol errors
    localparam int RESET_CYC      = 1200;  // low width that latches a frame
    localparam int MAX_PIXELS     = 6;     // pixels reported per frame

    localparam int CNT_W = 11;             // holds RESET_CYC without wrapping

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } rx_state_t;

    // Increment a width counter, holding it at RESET_CYC instead of wrapping.
    function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (c >= CNT_W'(RESET_CYC)) begin
            r = CNT_W'(RESET_CYC);
        end else begin
            r = c + CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/ws2812_rx_din_sync.sv
// din_sync: two-flop synchronizer for the asynchronous WS2812 input, plus a
// third flop of history so rise/fall strobes mark the first synced cycle of
// each new level.
module din_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain and one cycle of synced history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 NRZ stream receiver. Measures synced high widths, decodes
// bits, assembles 24-bit pixels and detects the latch gap ending a frame.
// Optional pass-through of the stream after pixel 0 is built when the macro
// WS2812_RX_FORWARD_EN is defined; otherwise dout is tied low.
module ws2812_rx
    import ws2812_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [7:0]  pixel_idx,
    output logic        frame_done,
    output logic        err,
    output logic        dout
);

    logic level, rise, fall;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [23:0]      sr_q, sr_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic             any_bit_q, any_bit_d;
    logic [7:0]       pix_cnt_q, pix_cnt_d;
    logic [23:0]      pixel_data_q, pixel_data_d;
    logic             pixel_valid_q, pixel_valid_d;
    logic [7:0]       pixel_idx_q, pixel_idx_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q, err_d;

    logic bit_ev, bit_val, ovf_ev, gap_ev, resync_ev;

    din_sync u_sync (
        .clk   (clk),
        .rst_n (reset),
        .din   (din),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // State, width counter, pixel assembly and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= SYNC;
            cnt_q         <= '0;
            sr_q          <= 24'd0;
            bit_cnt_q     <= 5'd0;
            any_bit_q     <= 1'b0;
            pix_cnt_q     <= 8'd0;
            pixel_data_q  <= 24'd0;
            pixel_valid_q <= 1'b0;
            pixel_idx_q   <= 8'd0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            any_bit_q     <= any_bit_d;
            pix_cnt_q     <= pix_cnt_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_idx_q   <= pixel_idx_d;
            frame_done_q  <= frame_done_d;
            err_q         <= err_d;
        end
    end

    // Next state and width counting; flags the bit, overflow and gap events.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cnt_inc   = cnt_inc_sat(cnt_q);
        bit_ev    = 1'b0;
        bit_val   = 1'b0;
        ovf_ev    = 1'b0;
        gap_ev    = 1'b0;
        resync_ev = 1'b0;
        case (state_q)
            SYNC: begin
                if (level) begin
                    cnt_d = '0;
                end else if (cnt_inc >= CNT_W'(RESET_CYC)) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    resync_ev = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d = LOW;
                    cnt_d   = CNT_W'(1);
                    if (cnt_q >= CNT_W'(MIN_HIGH_CYC)) begin
                        bit_ev  = 1'b1;
                        bit_val = (cnt_q >= CNT_W'(BIT_THRESH_CYC));
                    end else begin
                        bit_ev = 1'b0;
                    end
                end else if (cnt_inc > CNT_W'(MAX_HIGH_CYC)) begin
                    state_d = SYNC;
                    cnt_d   = '0;
                    ovf_ev  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_inc >= CNT_W'(RESET_CYC)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    gap_ev  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = SYNC;
                cnt_d   = '0;
            end
        endcase
    end

    // Pixel assembly, frame bookkeeping and next values of the output strobes.
    always_comb begin
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        any_bit_d     = any_bit_q;
        pix_cnt_d     = pix_cnt_q;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = 1'b0;
        pixel_idx_d   = pixel_idx_q;
        frame_done_d  = 1'b0;
        err_d         = 1'b0;
        if (bit_ev) begin
            sr_d      = {sr_q[22:0], bit_val};
            any_bit_d = 1'b1;
            if (bit_cnt_q == 5'd23) begin
                bit_cnt_d = 5'd0;
                if (pix_cnt_q < 8'(MAX_PIXELS)) begin
                    pixel_valid_d = 1'b1;
                    pixel_data_d  = {sr_q[22:0], bit_val};
                    pixel_idx_d   = pix_cnt_q;
                end else begin
                    pixel_valid_d = 1'b0;
                end
                if (pix_cnt_q != 8'd255) begin
                    pix_cnt_d = pix_cnt_q + 8'd1;
                end else begin
                    pix_cnt_d = pix_cnt_q;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end else if (gap_ev) begin
            // A frame ending mid-pixel reports the lost partial pixel as err.
            frame_done_d = any_bit_q;
            err_d        = any_bit_q && (bit_cnt_q != 5'd0);
            sr_d         = 24'd0;
            bit_cnt_d    = 5'd0;
            any_bit_d    = 1'b0;
            pix_cnt_d    = 8'd0;
        end else if (ovf_ev) begin
            err_d     = 1'b1;
            sr_d      = 24'd0;
            bit_cnt_d = 5'd0;
        end else if (resync_ev) begin
            sr_d      = 24'd0;
            bit_cnt_d = 5'd0;
            any_bit_d = 1'b0;
            pix_cnt_d = 8'd0;
        end else begin
            sr_d = sr_q;
        end
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_idx   = pixel_idx_q;
    assign frame_done  = frame_done_q;
    assign err         = err_q;

`ifdef WS2812_RX_FORWARD_EN
    logic dout_q, dout_d;

    // Forward the synced stream once pixel 0 of the frame has been consumed.
    always_comb begin
        dout_d = 1'b0;
        if ((state_q != SYNC) && (pix_cnt_q != 8'd0)) begin
            dout_d = level;
        end else begin
            dout_d = 1'b0;
        end
    end

    // Register the forwarded level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
`else
    assign dout = 1'b0;
`endif

endmodule
